// File: rtl/clarvi_mem_sequencer.sv
// Load/store sequencer for the sliced Clarvi datapath: builds the effective address
// slice by slice, then issues lane-aligned beats on a narrow data port and reassembles loads.
module clarvi_mem_sequencer #(
  parameter int SLICE_WIDTH      = 16,
  parameter int NUM_SLICES       = 4,
  parameter int PORT_BYTES       = 2,
  parameter int DATA_ADDR_WIDTH  = 14,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic                                                    clock,
  input  logic                                                    reset,
  input  logic                                                    slice_valid,
  input  logic [((NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1)-1:0] slice_index,
  input  logic [SLICE_WIDTH-1:0]                                  rs1_slice,
  input  logic [SLICE_WIDTH-1:0]                                  imm_slice,
  input  logic [SLICE_WIDTH-1:0]                                  rs2_slice,
  input  logic                                                    op_read,
  input  logic                                                    op_write,
  input  logic [1:0]                                              mem_width,
  input  logic                                                    load_unsigned,
  input  logic                                                    flush,
  output logic                                                    stall_upstream,
  output logic [DATA_ADDR_WIDTH-1:0]                              main_address,
  output logic [PORT_BYTES-1:0]                                   main_byte_enable,
  output logic                                                    main_read_enable,
  output logic                                                    main_write_enable,
  output logic [8*PORT_BYTES-1:0]                                 main_write_data,
  input  logic                                                    main_wait,
  input  logic [8*PORT_BYTES-1:0]                                 main_read_data,
  input  logic                                                    main_read_valid,
  output logic [SLICE_WIDTH*NUM_SLICES-1:0]                       load_data,
  output logic                                                    done,
  output logic                                                    mem_address_error
);

  localparam int XLEN       = SLICE_WIDTH * NUM_SLICES;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int LANE_BITS  = $clog2(PORT_BYTES);
  localparam int OFF_W      = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int SPAN_BYTES = XLEN / 8 + PORT_BYTES;
  localparam int MAX_BEATS  = (SPAN_BYTES + PORT_BYTES - 1) / PORT_BYTES;
  localparam int BEAT_W     = $clog2(MAX_BEATS + 1);
  localparam int RANGE_LSB  = DATA_ADDR_WIDTH + LANE_BITS;
  localparam int SIGN_W     = $clog2(XLEN);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t                        state;
  logic [XLEN-1:0]               addr_acc;
  logic [XLEN-1:0]               store_acc;
  logic                          carry;
  logic [BEAT_W-1:0]             beat;
  logic [BEAT_W-1:0]             last_beat;
  logic [DATA_ADDR_WIDTH-1:0]    word_addr;
  logic [OFF_W-1:0]              off_r;
  logic [1:0]                    width_r;
  logic                          is_write;
  logic                          uns_r;
  logic [SPAN_BYTES-1:0]         span_be;
  logic [8*SPAN_BYTES-1:0]       span_wdata;
  logic [8*SPAN_BYTES-1:0]       assembly;
  logic                          err_pulse;

  logic                          slice_cin;
  logic [SLICE_WIDTH:0]          slice_sum;
  logic [XLEN-1:0]               next_addr;
  logic [XLEN-1:0]               next_store;
  logic                          last_slice;
  logic [4:0]                    nb;
  logic [OFF_W-1:0]              off;
  logic                          size_err;
  logic                          range_err;
  logic                          align_err;
  logic                          addr_err;
  logic [BEAT_W-1:0]             next_last_beat;
  logic [SPAN_BYTES-1:0]         next_span_be;
  logic [8*SPAN_BYTES-1:0]       next_span_wdata;

  // Slice arithmetic and access decode, evaluated against the slice arriving this cycle.
  always_comb begin
    // NOTE: every variable gets a full default before any partial overwrite, so no latch is inferred.
    slice_cin  = (slice_index == '0) ? 1'b0 : carry;
    slice_sum  = {1'b0, rs1_slice} + {1'b0, imm_slice} + {{SLICE_WIDTH{1'b0}}, slice_cin};
    next_addr  = addr_acc;
    next_addr[slice_index*SLICE_WIDTH +: SLICE_WIDTH] = slice_sum[SLICE_WIDTH-1:0];
    next_store = store_acc;
    next_store[slice_index*SLICE_WIDTH +: SLICE_WIDTH] = rs2_slice;

    last_slice = slice_valid && (slice_index == IDX_W'(NUM_SLICES - 1));
    nb         = 5'd1 << mem_width;
    off        = (LANE_BITS > 0) ? next_addr[OFF_W-1:0] : '0;
    size_err   = (int'(nb) * 8) > XLEN;
    range_err  = (next_addr >> RANGE_LSB) != '0;
    align_err  = (ALLOW_MISALIGNED == 0) && ((next_addr[4:0] & (nb - 5'd1)) != 5'd0);
    addr_err   = size_err || range_err || align_err;

    next_last_beat  = BEAT_W'((int'(off) + int'(nb) + PORT_BYTES - 1) / PORT_BYTES - 1);
    next_span_be    = ((SPAN_BYTES'(1) << nb) - SPAN_BYTES'(1)) << off;
    next_span_wdata = (8*SPAN_BYTES)'(next_store) << {off, 3'b000};
  end

  logic [PORT_BYTES-1:0]   cur_be;
  logic [8*PORT_BYTES-1:0] cur_wdata;
  logic                    issuing;

  assign cur_be    = span_be[beat*PORT_BYTES +: PORT_BYTES];
  assign cur_wdata = span_wdata[beat*8*PORT_BYTES +: 8*PORT_BYTES];
  assign issuing   = (state == ST_ISSUE) && !flush && !reset;

  assign main_read_enable  = issuing && !is_write;
  assign main_write_enable = issuing && is_write;
  assign main_address      = (state == ST_ISSUE) ? word_addr + DATA_ADDR_WIDTH'(beat) : '0;
  assign main_byte_enable  = (state == ST_ISSUE) ? cur_be : '0;
  assign main_write_data   = (state == ST_ISSUE) ? cur_wdata : '0;
  assign stall_upstream    = (state == ST_ISSUE) || (state == ST_WAIT);
  assign done              = (state == ST_DONE);
  assign mem_address_error = err_pulse;

  // Load result: drop the leading offset bytes, keep nb bytes, then extend from the top kept bit.
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   keep_mask;
  logic [7:0]        nbits;
  logic [SIGN_W-1:0] sign_pos;
  logic              sign;
  logic [XLEN-1:0]   load_ext;

  always_comb begin
    nbits     = {3'b000, 5'd1 << width_r} << 3;
    raw       = XLEN'(assembly >> {off_r, 3'b000});
    keep_mask = (XLEN'(1) << nbits) - XLEN'(1);
    sign_pos  = SIGN_W'(nbits - 8'd1);
    sign      = raw[sign_pos];
    load_ext  = (sign && !uns_r) ? (raw | ~keep_mask) : (raw & keep_mask);
  end

  assign load_data = (state == ST_DONE && !is_write) ? load_ext : '0;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (reset || flush) begin
      state      <= ST_IDLE;
      addr_acc   <= '0;
      store_acc  <= '0;
      carry      <= 1'b0;
      beat       <= '0;
      last_beat  <= '0;
      word_addr  <= '0;
      off_r      <= '0;
      width_r    <= '0;
      is_write   <= 1'b0;
      uns_r      <= 1'b0;
      span_be    <= '0;
      span_wdata <= '0;
      assembly   <= '0;
      err_pulse  <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (slice_valid) begin
            addr_acc  <= next_addr;
            store_acc <= next_store;
            carry     <= slice_sum[SLICE_WIDTH];
            if (last_slice && (op_read || op_write)) begin
              if (addr_err) begin
                err_pulse <= 1'b1;
              end else begin
                state      <= ST_ISSUE;
                beat       <= '0;
                last_beat  <= next_last_beat;
                word_addr  <= next_addr[LANE_BITS +: DATA_ADDR_WIDTH];
                off_r      <= off;
                width_r    <= mem_width;
                is_write   <= op_write;
                uns_r      <= load_unsigned;
                span_be    <= next_span_be;
                span_wdata <= next_span_wdata;
                assembly   <= '0;
              end
            end
          end
        end
        ST_ISSUE: begin
          if (!main_wait) begin
            if (!is_write)               state <= ST_WAIT;
            else if (beat == last_beat)  state <= ST_DONE;
            else                         beat  <= beat + BEAT_W'(1);
          end
        end
        ST_WAIT: begin
          if (main_read_valid) begin
            for (int i = 0; i < PORT_BYTES; i++) begin
              if (cur_be[i]) assembly[(int'(beat) * PORT_BYTES + i) * 8 +: 8] <= main_read_data[i*8 +: 8];
            end
            if (beat == last_beat) begin
              state <= ST_DONE;
            end else begin
              beat  <= beat + BEAT_W'(1);
              state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
